// File: rtl/ibuffer_col_pp.sv
`default_nettype none
// ============================================================================
//  Module      : ibuffer_col_pp
//  Description : Double-buffered (ping-pong) column input buffer for the edge
//                of a systolic array. A column word is written into a shadow
//                bank and swapped into the active bank on a shift request.
//                The active bank is then shifted out one element per cycle,
//                element 0 first. An optional register chain adds SKEW cycles
//                of delay to stagger neighbouring buffers.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           : sole clock, all state on rising edge
//    rst           : asynchronous active-high reset
//    i_write_en    : load i_iword into the shadow bank
//    i_iword       : column word, element 0 in the most significant DW bits
//    i_shift_en    : request to start shifting out the next column
//    o_od          : output element towards the array edge
//    o_ovalid      : o_od carries a real element
//    o_shift_en    : i_shift_en delayed one cycle, for the adjacent buffer
//    o_shadow_full : shadow bank holds an unconsumed word
//    o_busy        : FSM is shifting a column
//    o_done        : pulse while the last element of a column is shifted out
//    o_ovf         : sticky, a full shadow word was overwritten
// ============================================================================
module ibuffer_col_pp #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int SKEW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_write_en,
    input  logic [DEPTH*DW-1:0]   i_iword,
    input  logic                  i_shift_en,
    output logic [DW-1:0]         o_od,
    output logic                  o_ovalid,
    output logic                  o_shift_en,
    output logic                  o_shadow_full,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf
);

    localparam int              C_BW   = DEPTH * DW;
    localparam int              C_CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(DEPTH - 1);
    localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [C_CW-1:0]    r_cnt;
    logic [C_BW-1:0]    r_active;
    logic [C_BW-1:0]    r_shadow;
    logic               r_shadow_full;
    logic               r_ovf;
    logic               r_shift_en_d;
    logic [DW-1:0]      r_od_pre;
    logic               r_ov_pre;

    logic               w_at_last;
    logic               w_swap;

    // A column may be chained onto the previous one only on its final cycle,
    // which keeps back-to-back columns free of bubbles.
    assign w_at_last = (r_state == S_SHIFT) && (r_cnt == C_LAST);
    assign w_swap    = i_shift_en && r_shadow_full &&
                       ((r_state == S_IDLE) || w_at_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_active      <= '0;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_ovf         <= 1'b0;
            r_shift_en_d  <= 1'b0;
            r_od_pre      <= '0;
            r_ov_pre      <= 1'b0;
        end else begin
            r_shift_en_d <= i_shift_en;

            // A write in the swap cycle wins: the new word stays pending.
            if (i_write_en) begin
                r_shadow      <= i_iword;
                r_shadow_full <= 1'b1;
            end else if (w_swap) begin
                r_shadow_full <= 1'b0;
            end

            if (i_write_en && r_shadow_full && !w_swap) begin
                r_ovf <= 1'b1;
            end

            // Pre-skew output register: zero whenever nothing is emitted.
            if (r_state == S_SHIFT) begin
                r_od_pre <= r_active[C_BW-1 -: DW];
                r_ov_pre <= 1'b1;
            end else begin
                r_od_pre <= '0;
                r_ov_pre <= 1'b0;
            end

            if (w_swap) begin
                r_active <= r_shadow;
                r_cnt    <= '0;
                r_state  <= S_SHIFT;
            end else if (r_state == S_SHIFT) begin
                r_active <= {r_active[C_BW-DW-1:0], {DW{1'b0}}};
                if (w_at_last) begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_cnt   <= r_cnt + C_ONE;
                end
            end
        end
    end

    generate
        if (SKEW == 0) begin : g_no_skew
            assign o_od     = r_od_pre;
            assign o_ovalid = r_ov_pre;
        end else begin : g_skew
            logic [DW:0] r_pipe [SKEW];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SKEW; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= {r_ov_pre, r_od_pre};
                    for (int i = 1; i < SKEW; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign {o_ovalid, o_od} = r_pipe[SKEW-1];
        end
    endgenerate

    assign o_shift_en    = r_shift_en_d;
    assign o_shadow_full = r_shadow_full;
    assign o_busy        = (r_state == S_SHIFT);
    assign o_done        = w_at_last;
    assign o_ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ibuffer_col_pp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibuffer_col_pp
//  Description : Testbench for ibuffer_col_pp. Two instances (SKEW=0 and
//                SKEW=3) share all inputs and are compared against a
//                queue-based reference model of the column buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ibuffer_col_pp;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        sen;
    logic [31:0] iword;

    logic [7:0] od0, od3;
    logic       ov0, seno0, sf0, busy0, done0, ovf0;
    logic       ov3, seno3, sf3, busy3, done3, ovf3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ibuffer_col_pp #(.DW(DW), .DEPTH(DEPTH), .SKEW(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_write_en(we), .i_iword(iword), .i_shift_en(sen),
        .o_od(od0), .o_ovalid(ov0), .o_shift_en(seno0), .o_shadow_full(sf0),
        .o_busy(busy0), .o_done(done0), .o_ovf(ovf0)
    );

    ibuffer_col_pp #(.DW(DW), .DEPTH(DEPTH), .SKEW(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_write_en(we), .i_iword(iword), .i_shift_en(sen),
        .o_od(od3), .o_ovalid(ov3), .o_shift_en(seno3), .o_shadow_full(sf3),
        .o_busy(busy3), .o_done(done3), .o_ovf(ovf3)
    );

    // ---------------- reference model ----------------
    logic [7:0]  m_q [$];       // elements still to leave the active bank
    logic [31:0] m_shadow;
    logic        m_sf, m_ovf, m_seno;
    logic [7:0]  m_od0, m_od3;
    logic        m_ov0, m_ov3;
    logic [8:0]  m_dly [3];

    task automatic model_reset();
        m_q.delete();
        m_shadow = '0;
        m_sf = 0; m_ovf = 0; m_seno = 0;
        m_od0 = '0; m_ov0 = 0; m_od3 = '0; m_ov3 = 0;
        for (int i = 0; i < 3; i++) m_dly[i] = '0;
    endtask

    task automatic model_edge();
        logic       swap;
        logic [7:0] nod;
        logic       nov;
        swap = sen && m_sf && (m_q.size() <= 1);
        if (we && m_sf && !swap) m_ovf = 1;
        if (m_q.size() > 0) begin
            nod = m_q.pop_front();
            nov = 1;
        end else begin
            nod = '0;
            nov = 0;
        end
        if (swap) begin
            for (int i = 0; i < DEPTH; i++) m_q.push_back(m_shadow[31-8*i -: 8]);
        end
        if (we) begin
            m_shadow = iword;
            m_sf = 1;
        end else if (swap) begin
            m_sf = 0;
        end
        m_seno = sen;
        {m_ov3, m_od3} = m_dly[2];
        m_dly[2] = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = {nov, nod};
        m_od0 = nod;
        m_ov0 = nov;
    endtask

    function automatic logic [27:0] act_vec();
        return {od0, ov0, busy0, done0, sf0, ovf0, seno0,
                od3, ov3, busy3, done3, sf3, ovf3, seno3};
    endfunction

    function automatic logic [27:0] exp_vec();
        logic b, d;
        b = (m_q.size() != 0);
        d = (m_q.size() == 1);
        return {m_od0, m_ov0, b, d, m_sf, m_ovf, m_seno,
                m_od3, m_ov3, b, d, m_sf, m_ovf, m_seno};
    endfunction

    // Drive one cycle of inputs (from a negedge), advance model and DUT,
    // and return at the following negedge.
    task automatic step(input logic w, input logic [31:0] word, input logic s);
        we = w; iword = word; sen = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        we = 0; sen = 0; iword = '0;
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        we = 0; sen = 0; iword = '0;
        rst = 1;
        model_reset();
        #1;
        n_cmp++;
        if (act_vec() !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", act_vec(), 28'h0);
        end
        @(negedge clk);
        n_cmp++;
        if (act_vec() !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", act_vec(), 28'h0);
        end
        rst = 0;
        step(1, 32'hCAFEF00D, 0);
        n_cmp++;
        if ({sf0, busy0, ov0} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_first_edge: got sf/busy/ov=%b expected 100", {sf0, busy0, ov0});
        end
    endtask

    task automatic test_single();
        logic [7:0] ref4 [4];
        logic [7:0] e_od, e_od3;
        logic       e_ov, e_ov3, e_done;
        ref4[0] = 8'h11; ref4[1] = 8'h22; ref4[2] = 8'h33; ref4[3] = 8'h44;
        apply_reset();
        step(1, 32'h11223344, 0);
        step(0, '0, 1);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_accept: got %h expected %h", act_vec(), exp_vec());
        end
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, 0);
            e_ov   = (k <= 4);
            e_od   = e_ov ? ref4[k-1] : 8'h00;
            e_done = (k == 3);
            e_ov3  = (k >= 4) && (k <= 7);
            e_od3  = e_ov3 ? ref4[k-4] : 8'h00;
            n_cmp++;
            if ({od0, ov0, done0, od3, ov3} !== {e_od, e_ov, e_done, e_od3, e_ov3}) begin
                n_fail++;
                $display("FAIL single_k%0d: got od=%h ov=%b done=%b od3=%h ov3=%b expected %h %b %b %h %b",
                         k, od0, ov0, done0, od3, ov3, e_od, e_ov, e_done, e_od3, e_ov3);
            end
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model_k%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [8];
        logic [7:0] e_od;
        logic       e_ov;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        seq[4] = 8'hAA; seq[5] = 8'hBB; seq[6] = 8'hCC; seq[7] = 8'hDD;
        apply_reset();
        step(1, 32'h11223344, 0);
        step(0, '0, 1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)      step(1, 32'hAABBCCDD, 0);
            else if (k == 4) step(0, '0, 1);     // FSM sits at the last element
            else             step(0, '0, 0);
            e_ov = (k <= 8);
            e_od = e_ov ? seq[k-1] : 8'h00;
            n_cmp++;
            if ({od0, ov0} !== {e_od, e_ov}) begin
                n_fail++;
                $display("FAIL b2b_k%0d: got od=%h ov=%b expected od=%h ov=%b", k, od0, ov0, e_od, e_ov);
            end
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_model_k%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_no_shadow();
        apply_reset();
        step(0, '0, 1);
        n_cmp++;
        if ({busy0, ov0, seno0} !== 3'b001) begin
            n_fail++;
            $display("FAIL noshadow_req: got busy/ov/seno=%b expected 001", {busy0, ov0, seno0});
        end
        step(0, '0, 0);
        n_cmp++;
        if ({busy0, ov0, seno0, ov3} !== 4'b0000) begin
            n_fail++;
            $display("FAIL noshadow_after: got busy/ov/seno/ov3=%b expected 0000", {busy0, ov0, seno0, ov3});
        end
    endtask

    task automatic test_ovf();
        apply_reset();
        step(1, 32'h01020304, 0);
        n_cmp++;
        if (ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_first_write: got %b expected 0", ovf0);
        end
        step(1, 32'h05060708, 0);
        step(0, '0, 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, '0, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_model_k%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
            if (k == 1) begin
                n_cmp++;
                if ({od0, ov0, ovf0} !== {8'h05, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL ovf_second_word: got od=%h ov=%b ovf=%b expected 05 1 1", od0, ov0, ovf0);
                end
            end
        end
        n_cmp++;
        if (ovf0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf0);
        end
        apply_reset();
        n_cmp++;
        if (ovf0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: got %b expected 0", ovf0);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(1, 32'h11223344, 0);
        step(0, '0, 1);
        step(0, '0, 0);                         // counter now at 1
        rst = 1;
        #1;
        n_cmp++;
        if (act_vec() !== 28'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h expected %h", act_vec(), 28'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 8; k++) begin
            step(0, '0, (k == 2));
            n_cmp++;
            if ({ov0, ov3, busy0} !== 3'b000 || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rstmid_k%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int chunk = 0; chunk < 4; chunk++) begin
            apply_reset();
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(0, 79) == 0) begin
                    rst = 1;
                    #1;
                    model_reset();
                    n_cmp++;
                    if (act_vec() !== exp_vec()) begin
                        n_fail++;
                        $display("FAIL rand_rst_c%0d_k%0d: got %h expected %h", chunk, k, act_vec(), exp_vec());
                    end
                    @(negedge clk);
                    rst = 0;
                end
                step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) == 0);
                n_cmp++;
                if (act_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rand_c%0d_k%0d: got %h expected %h", chunk, k, act_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_shadow();
        test_ovf();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
